// File: rtl/speck_sched_pkg.sv
// rtl/speck_sched_pkg.sv - shared constants, state encoding and rotate helpers for the SPECK round scheduler
//
// Purpose: word and rotation constants for SPECK-128/128, the scheduler
// state encoding, reset constants and small rotate helpers.
// Ports: none (package).

package speck_sched_pkg;

    localparam int WORD_W = 64;
    localparam int ROT_A  = 8;
    localparam int ROT_B  = 3;
    localparam int RND_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam state_t              RST_STATE = ST_IDLE;
    localparam logic [WORD_W-1:0]   RST_WORD  = '0;
    localparam logic [RND_W-1:0]    RST_RND   = '0;
    localparam logic [2*WORD_W-1:0] RST_CT    = '0;

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v, input int n);
        return (v >> n) | (v << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v, input int n);
        return (v << n) | (v >> (WORD_W - n));
    endfunction

endpackage

// File: rtl/speck_round_step.sv
// rtl/speck_round_step.sv - combinational SPECK-128/128 round plus key-schedule step
//
// Purpose: maps (x, y, k, l, rnd) to the next (x, y, k, l). The round uses
// the incoming k; the key schedule uses rnd as its round constant.
// Ports:
//   x_i, y_i  in   64  current cipher state words
//   k_i, l_i  in   64  current round key and key-schedule word
//   rnd_i     in    6  round index used as key-schedule constant
//   x_o, y_o  out  64  cipher state after one round
//   k_o, l_o  out  64  key-schedule state after one step

module speck_round_step
    import speck_sched_pkg::*;
(
    input  logic [WORD_W-1:0] x_i,
    input  logic [WORD_W-1:0] y_i,
    input  logic [WORD_W-1:0] k_i,
    input  logic [WORD_W-1:0] l_i,
    input  logic [RND_W-1:0]  rnd_i,
    output logic [WORD_W-1:0] x_o,
    output logic [WORD_W-1:0] y_o,
    output logic [WORD_W-1:0] k_o,
    output logic [WORD_W-1:0] l_o
);

    assign x_o = (ror(x_i, ROT_A) + y_i) ^ k_i;
    assign y_o = rol(y_i, ROT_B) ^ x_o;
    assign l_o = (ror(l_i, ROT_A) + k_i) ^ {{(WORD_W-RND_W){1'b0}}, rnd_i};
    assign k_o = rol(k_i, ROT_B) ^ l_o;

endmodule

// File: rtl/speck_round_scheduler.sv
// rtl/speck_round_scheduler.sv - round-robin shared iterative SPECK-128/128 engine
//
// Purpose: arbitrates NUM_REQ requesters round-robin onto one iterative
// SPECK-128/128 datapath, runs NUM_ROUNDS rounds (one per clock) and
// returns the ciphertext tagged with the owning requester index.
// Optional build macro: SPECK_SCHED_DBG_EN adds dbg_state / dbg_round.
// Ports:
//   clk, rst        in   1            clock, synchronous active-high reset
//   req_valid       in   NUM_REQ      per-requester job request
//   req_ready       out  NUM_REQ      one-hot (or zero) accept, IDLE only
//   req_key         in   NUM_REQ*128  packed keys, requester r at [128r +: 128]
//   req_plaintext   in   NUM_REQ*128  packed plaintexts, same packing
//   rsp_valid       out  1            ciphertext available
//   rsp_ready       in   1            consumer accepts the response
//   rsp_id          out  ID_W         owner of the response
//   rsp_ciphertext  out  128          {x, y}
//   busy            out  1            state is not IDLE
//   dbg_state       out  2            (debug build) IDLE=0, RUN=1, DONE=2
//   dbg_round       out  6            (debug build) live round counter

module speck_round_scheduler
    import speck_sched_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int NUM_ROUNDS = 32,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_key,
    input  logic [NUM_REQ*128-1:0] req_plaintext,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [127:0]           rsp_ciphertext,
    output logic                   busy
`ifdef SPECK_SCHED_DBG_EN
    ,
    output logic [1:0]             dbg_state,
    output logic [5:0]             dbg_round
`endif
);

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

    state_t              state_q;
    logic [ID_W-1:0]     ptr_q;
    logic [WORD_W-1:0]   x_q, y_q, k_q, l_q;
    logic [WORD_W-1:0]   x_d, y_d, k_d, l_d;
    logic [RND_W-1:0]    rnd_q;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [127:0]        rsp_ct_q;

    logic                found;
    logic [NUM_REQ-1:0]  grant_vec;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     ptr_d;
    logic [127:0]        sel_key;
    logic [127:0]        sel_pt;

    // Round-robin pick: the first pass only considers indices at or above
    // ptr; the second pass covers the wrap-around when none of those request.
    always_comb begin
        found     = 1'b0;
        grant_vec = '0;
        grant_id  = '0;
        sel_key   = '0;
        sel_pt    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (ID_W'(i) >= ptr_q)) begin
                found        = 1'b1;
                grant_vec[i] = 1'b1;
                grant_id     = ID_W'(i);
                sel_key      = req_key[i*128 +: 128];
                sel_pt       = req_plaintext[i*128 +: 128];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found        = 1'b1;
                grant_vec[i] = 1'b1;
                grant_id     = ID_W'(i);
                sel_key      = req_key[i*128 +: 128];
                sel_pt       = req_plaintext[i*128 +: 128];
            end
        end
        ptr_d = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end

    assign req_ready = (state_q == ST_IDLE && !rst) ? grant_vec : '0;

    speck_round_step u_step (
        .x_i   (x_q),
        .y_i   (y_q),
        .k_i   (k_q),
        .l_i   (l_q),
        .rnd_i (rnd_q),
        .x_o   (x_d),
        .y_o   (y_d),
        .k_o   (k_d),
        .l_o   (l_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_STATE;
            ptr_q       <= '0;
            x_q         <= RST_WORD;
            y_q         <= RST_WORD;
            k_q         <= RST_WORD;
            l_q         <= RST_WORD;
            rnd_q       <= RST_RND;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_ct_q    <= RST_CT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        x_q      <= sel_pt[127:64];
                        y_q      <= sel_pt[63:0];
                        k_q      <= sel_key[63:0];
                        l_q      <= sel_key[127:64];
                        rnd_q    <= '0;
                        rsp_id_q <= grant_id;
                        ptr_q    <= ptr_d;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    x_q   <= x_d;
                    y_q   <= y_d;
                    k_q   <= k_d;
                    l_q   <= l_d;
                    rnd_q <= rnd_q + 1'b1;
                    // The response word is captured from the step output so
                    // rsp_valid and rsp_ciphertext appear on the same edge.
                    if (rnd_q == LAST_RND) begin
                        rsp_ct_q    <= {x_d, y_d};
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_ciphertext = rsp_ct_q;
    assign busy           = (state_q != ST_IDLE);

`ifdef SPECK_SCHED_DBG_EN
    assign dbg_state = state_q;
    assign dbg_round = rnd_q;
`endif

endmodule

// File: tb/tb_speck_round_scheduler.sv
// tb/tb_speck_round_scheduler.sv - scoreboard bench for speck_round_scheduler

module tb_speck_round_scheduler;

    localparam int A_RND = 32;
    localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] KAT_PT  = 128'h6c61766975716520_7469206564616d20;
    localparam logic [127:0] KAT_CT  = 128'ha65d985179783265_7860fedf5c570d18;
    localparam logic [127:0] K1 = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] P1 = 128'h0000000000000001_0000000000000002;
    localparam logic [127:0] K2 = 128'hffffffffffffffff_ffffffffffffffff;
    localparam logic [127:0] P2 = 128'h8000000000000000_0000000000000000;
    localparam logic [127:0] K3 = 128'h1f1e1d1c1b1a1918_1716151413121110;
    localparam logic [127:0] P3 = 128'hdeadbeefcafef00d_0123456789abcdef;

    typedef struct {
        int           id;
        logic [127:0] ct;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // DUT A: three requesters, full 32-round cipher
    logic         a_rst;
    logic [2:0]   a_req_valid, a_req_ready;
    logic [383:0] a_req_key, a_req_pt;
    logic         a_rsp_valid, a_rsp_ready, a_busy;
    logic [1:0]   a_rsp_id;
    logic [127:0] a_rsp_ct;

    // DUT B: single requester, one round
    logic         b_rst;
    logic [0:0]   b_req_valid, b_req_ready;
    logic [127:0] b_req_key, b_req_pt;
    logic         b_rsp_valid, b_rsp_ready, b_busy;
    logic [0:0]   b_rsp_id;
    logic [127:0] b_rsp_ct;

`ifdef SPECK_SCHED_DBG_EN
    logic [1:0] a_dbg_state, b_dbg_state;
    logic [5:0] a_dbg_round, b_dbg_round;
`endif

    speck_round_scheduler #(.NUM_REQ(3), .NUM_ROUNDS(A_RND)) u_dut_a (
        .clk            (clk),
        .rst            (a_rst),
        .req_valid      (a_req_valid),
        .req_ready      (a_req_ready),
        .req_key        (a_req_key),
        .req_plaintext  (a_req_pt),
        .rsp_valid      (a_rsp_valid),
        .rsp_ready      (a_rsp_ready),
        .rsp_id         (a_rsp_id),
        .rsp_ciphertext (a_rsp_ct),
        .busy           (a_busy)
`ifdef SPECK_SCHED_DBG_EN
        ,
        .dbg_state      (a_dbg_state),
        .dbg_round      (a_dbg_round)
`endif
    );

    speck_round_scheduler #(.NUM_REQ(1), .NUM_ROUNDS(1)) u_dut_b (
        .clk            (clk),
        .rst            (b_rst),
        .req_valid      (b_req_valid),
        .req_ready      (b_req_ready),
        .req_key        (b_req_key),
        .req_plaintext  (b_req_pt),
        .rsp_valid      (b_rsp_valid),
        .rsp_ready      (b_rsp_ready),
        .rsp_id         (b_rsp_id),
        .rsp_ciphertext (b_rsp_ct),
        .busy           (b_busy)
`ifdef SPECK_SCHED_DBG_EN
        ,
        .dbg_state      (b_dbg_state),
        .dbg_round      (b_dbg_round)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got an event with nothing queued, expected none", name);
    endtask

    // Textbook SPECK-128/128 encryption used to derive expected ciphertexts.
    function automatic logic [127:0] speck_ref(input logic [127:0] key, input logic [127:0] pt, input int rounds);
        logic [63:0] x, y, kk, ll;
        x  = pt[127:64];
        y  = pt[63:0];
        kk = key[63:0];
        ll = key[127:64];
        for (int i = 0; i < rounds; i++) begin
            x  = ({x[7:0], x[63:8]} + y) ^ kk;
            y  = {y[60:0], y[63:61]} ^ x;
            ll = ({ll[7:0], ll[63:8]} + kk) ^ 64'(i);
            kk = {kk[60:0], kk[63:61]} ^ ll;
        end
        return {x, y};
    endfunction

    function automatic int onehot_idx(input logic [2:0] v);
        for (int i = 0; i < 3; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    exp_t         a_exp_q[$];
    int           a_grant_q[$];
    logic [127:0] b_exp_q[$];
    exp_t         a_e;
    logic [127:0] b_ct;
    int           a_grant_cyc = 0;
    int           b_grant_cyc = 0;
    logic         a_prev_valid = 1'b0;
    logic         b_prev_valid = 1'b0;

    // Monitors: sample mid-cycle; a valid&ready seen here is the handshake of the next edge.
    always @(negedge clk) begin
        if ((a_req_ready & a_req_valid) != 3'b000) begin
            a_grant_cyc = cyc + 1;
            if (a_grant_q.size() == 0) unexpected("a_grant");
            else check("a_grant", 128'(onehot_idx(a_req_ready)), 128'(a_grant_q.pop_front()));
        end
        if (a_rsp_valid && !a_prev_valid)
            check("a_latency", 128'(cyc - a_grant_cyc), 128'(A_RND));
        a_prev_valid = a_rsp_valid;
        if (a_rsp_valid && a_rsp_ready) begin
            if (a_exp_q.size() == 0) unexpected("a_rsp");
            else begin
                a_e = a_exp_q.pop_front();
                check("a_rsp_id", 128'(a_rsp_id), 128'(a_e.id));
                check("a_rsp_ct", a_rsp_ct, a_e.ct);
            end
        end
    end

    always @(negedge clk) begin
        if ((b_req_ready & b_req_valid) != 1'b0) b_grant_cyc = cyc + 1;
        if (b_rsp_valid && !b_prev_valid)
            check("b_latency", 128'(cyc - b_grant_cyc), 128'd1);
        b_prev_valid = b_rsp_valid;
        if (b_rsp_valid && b_rsp_ready) begin
            if (b_exp_q.size() == 0) unexpected("b_rsp");
            else begin
                b_ct = b_exp_q.pop_front();
                check("b_rsp_id", 128'(b_rsp_id), 128'd0);
                check("b_rsp_ct", b_rsp_ct, b_ct);
            end
        end
    end

    task automatic a_expect(input int id, input logic [127:0] ct);
        exp_t e;
        e.id = id;
        e.ct = ct;
        a_exp_q.push_back(e);
        a_grant_q.push_back(id);
    endtask

    // Returns 1 ns after the handshake edge.
    task automatic a_wait_grant();
        int n = 0;
        @(negedge clk);
        while ((a_req_ready & a_req_valid) == 3'b000 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            tests++;
            fails++;
            $display("FAIL a_wait_grant: got no grant in 500 cycles, expected one");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic a_drain();
        int n = 0;
        while ((a_exp_q.size() != 0 || a_grant_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            tests++;
            fails++;
            $display("FAIL a_drain: got %0d responses outstanding, expected 0", a_exp_q.size());
            a_exp_q.delete();
            a_grant_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic b_job(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct);
        int n = 0;
        b_req_key = key;
        b_req_pt  = pt;
        b_exp_q.push_back(ct);
        b_req_valid = 1'b1;
        @(negedge clk);
        while (!b_req_ready[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        n = 0;
        while (b_exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL b_job: got no response in 100 cycles, expected one");
            b_exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1);
    end

    initial begin
        a_rst = 1'b1;
        b_rst = 1'b1;
        a_req_valid = '0;
        b_req_valid = '0;
        a_req_key = '0;
        a_req_pt = '0;
        b_req_key = '0;
        b_req_pt = '0;
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 128'(a_rsp_valid), 128'd0);
        check("rst_rsp_id", 128'(a_rsp_id), 128'd0);
        check("rst_rsp_ct", a_rsp_ct, 128'd0);
        check("rst_busy", 128'(a_busy), 128'd0);
        check("rst_b_busy", 128'(b_busy), 128'd0);
`ifdef SPECK_SCHED_DBG_EN
        check("rst_dbg_state", 128'(a_dbg_state), 128'd0);
        check("rst_dbg_round", 128'(a_dbg_round), 128'd0);
        check("rst_b_dbg_state", 128'(b_dbg_state), 128'd0);
        check("rst_b_dbg_round", 128'(b_dbg_round), 128'd0);
`endif
        a_req_valid = 3'b111;
        #1;
        check("rst_req_ready", 128'(a_req_ready), 128'd0);
        a_req_valid = 3'b000;
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Contention: all three hold valid; grants rotate 0,1,2,0.
        a_req_key = {K2, K1, KAT_KEY};
        a_req_pt  = {P2, P1, KAT_PT};
        a_expect(0, KAT_CT);
        a_expect(1, speck_ref(K1, P1, A_RND));
        a_expect(2, speck_ref(K2, P2, A_RND));
        a_expect(0, KAT_CT);
        a_req_valid = 3'b111;
        for (int n = 0; n < 4; n++) a_wait_grant();
        a_req_valid = 3'b000;
        a_drain();

        // Back-pressure in DONE with requester 2 waiting.
        a_req_key[255:128] = KAT_KEY;
        a_req_pt[255:128]  = KAT_PT;
        a_expect(1, KAT_CT);
        a_rsp_ready = 1'b0;
        a_req_valid = 3'b010;
        a_wait_grant();
        a_req_valid = 3'b100;
        a_expect(2, speck_ref(K2, P2, A_RND));
        begin
            int n = 0;
            @(negedge clk);
            while (!a_rsp_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) begin
                tests++;
                fails++;
                $display("FAIL bp_wait: got no rsp_valid in 100 cycles, expected one");
            end
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 128'(a_rsp_valid), 128'd1);
            check("bp_id", 128'(a_rsp_id), 128'd1);
            check("bp_ct", a_rsp_ct, KAT_CT);
            check("bp_req_ready", 128'(a_req_ready), 128'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_busy", 128'(a_busy), 128'd0);
        check("bp_idle_ready", 128'(a_req_ready), 128'b100);
        @(posedge clk);
        #1;
        a_req_valid = 3'b000;
        a_drain();

        // Reset during RUN at rnd=10: job dropped, pointer back to 0.
        a_grant_q.push_back(1);
        a_req_valid = 3'b010;
        a_wait_grant();
        a_req_valid = 3'b000;
        repeat (10) @(posedge clk);
        #1;
        a_rst = 1'b1;
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 128'(a_busy), 128'd0);
        check("mid_rst_valid", 128'(a_rsp_valid), 128'd0);
`ifdef SPECK_SCHED_DBG_EN
        check("mid_rst_dbg_state", 128'(a_dbg_state), 128'd0);
`endif
        @(posedge clk);
        #1;
        a_req_key[127:0] = K3;
        a_req_pt[127:0]  = P3;
        a_expect(0, speck_ref(K3, P3, A_RND));
        a_req_valid = 3'b101;
        a_wait_grant();
        a_req_valid = 3'b000;
`ifdef SPECK_SCHED_DBG_EN
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            if (i < 32) begin
                check("dbg_state_run", 128'(a_dbg_state), 128'd1);
                check("dbg_round_run", 128'(a_dbg_round), 128'(i));
            end else if (i == 32) begin
                check("dbg_state_done", 128'(a_dbg_state), 128'd2);
                check("dbg_round_done", 128'(a_dbg_round), 128'd32);
            end else begin
                check("dbg_state_idle", 128'(a_dbg_state), 128'd0);
            end
        end
`endif
        a_drain();

        // Single-round instance with hand-worked vectors.
        b_job(128'h0, {64'h1, 64'h0}, {64'h0100000000000000, 64'h0100000000000000});
        b_job(128'h0, {64'h0, 64'h1}, {64'h1, 64'h9});
        b_job({64'h0, 64'hff}, 128'h0, {64'hff, 64'hff});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
